pipe_stage_chain: RTL and testbench
===================================

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 The block SHALL have parameter WL, default 32, meaning data word width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of register stages, legal range 1..8.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1  SHALL mean that in_data holds a word offered by upstream.
REQ-006 Port in_ready  output  1  SHALL mean that the chain accepts in_data at this edge.
REQ-007 Port in_data  input  WL  SHALL be the upstream data word.
REQ-008 Port out_valid  output  1  SHALL mean that out_data holds a valid word for downstream.
REQ-009 Port out_ready  input  1  SHALL mean that downstream accepts out_data at this edge.
REQ-010 Port out_data  output  WL  SHALL be the word held in the last stage.
REQ-011 Port flush  input  1  SHALL be a synchronous request to discard all words in flight.
REQ-012 Port occupancy  output  clog2(DEPTH+1)  SHALL be the count of valid stages; it exists only when PIPE_OCC_EN is defined.

Function
REQ-013 Each stage k (0..DEPTH-1) SHALL hold a data register and a valid bit; stage 0 is fed by in_data and stage DEPTH-1 drives out_data/out_valid.
REQ-014 The stage ready signals SHALL be computed combinationally: ready(DEPTH-1) = ~valid(DEPTH-1) | out_ready; ready(k) = ~valid(k) | ready(k+1).
REQ-015 in_ready SHALL equal ready(0) & ~flush.
REQ-016 A transfer SHALL occur on an edge where the valid and ready of the same interface are both 1; no other word is consumed or produced.
REQ-017 When ready(k) = 1 and flush = 0, stage k SHALL load the data and valid of its predecessor (stage 0 loads in_data and in_valid & in_ready).
REQ-018 When ready(k) = 0, stage k SHALL hold its data and valid unchanged, so that back-pressure stalls only the stages behind the first occupied stage that cannot drain.
REQ-019 Bubbles SHALL collapse: an empty stage accepts a word even when out_ready = 0.
REQ-020 Latency from input transfer to out_valid SHALL be exactly DEPTH cycles when out_ready stays 1.
REQ-021 Sustained throughput SHALL be one word per cycle when in_valid = 1 and out_ready = 1.
REQ-022 Word order SHALL be preserved; no word is duplicated or dropped except by flush or reset.
REQ-023 flush = 1 at an edge SHALL clear every valid bit, leaving data registers unchanged, and SHALL take priority over any transfer at that edge; the input word offered during flush is not accepted, and the output word transfers if out_ready = 1.
REQ-024 When out_valid = 0, out_data SHALL hold the last value loaded into stage DEPTH-1.
REQ-025 Outputs SHALL not depend combinationally on in_data; in_ready depends combinationally on out_ready, flush and the valid bits only.

Reset
REQ-026 Asserting RST SHALL immediately clear all valid bits and all data registers to 0, giving out_valid = 0, out_data = 0 and occupancy = 0, independent of CLK.
REQ-027 While RST = 1, in_ready SHALL be 0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight words; the first edge after deassertion behaves as on an empty chain.

Configuration
REQ-029 With macro PIPE_OCC_EN defined, the occupancy port and counter SHALL exist; the counter is +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither, 0 on flush, and always equals the popcount of the valid bits.
REQ-030 Without PIPE_OCC_EN, the occupancy port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Latency: DEPTH=3, out_ready=1, single word 0xA5A5A5A5 -> out_valid=1 with that data exactly 3 edges after acceptance, for one cycle.
REQ-032 Streaming: DEPTH=2, 16 back-to-back words 0..15 with in_valid=1 and out_ready=1 -> outputs 0..15 in order on consecutive cycles, and in_ready never drops.
REQ-033 Back-pressure: DEPTH=4, out_ready=0, 6 words offered -> exactly 4 accepted, in_ready=0 afterwards, occupancy=4; out_ready=1 -> the 4 words drain in order, then the remaining 2.
REQ-034 Bubble collapse: DEPTH=3, one word in flight, out_ready=0 -> the next two words are accepted, then in_ready=0.
REQ-035 Flush: DEPTH=3, 3 valid words, flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, input word not accepted, out_data unchanged.
REQ-036 Reset: RST asserted asynchronously mid-stream between edges -> out_valid=0, out_data=0, in_ready=0 immediately; after release, a new word 0x1 emerges after DEPTH cycles.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-deep chain of valid/ready register stages with
// bubble collapse, synchronous flush and asynchronous active-high reset.
// Optional feature: define PIPE_OCC_EN to add the occupancy port and counter.
module pipe_stage_chain #(
    parameter int WL    = 32,
    parameter int DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_data,
    input  logic          flush
`ifdef PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] r_valid;
    logic [WL-1:0]    r_data [DEPTH];

    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_prev_valid;
    logic [WL-1:0]    w_prev_data [DEPTH];
    logic             w_in_xfer;

    localparam logic [DEPTH-1:0] AllOnes = {DEPTH{1'b1}};

    // Stage k may load when some stage at or ahead of it is empty, or downstream drains.
    always_comb begin
        w_ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_ready[k] = out_ready | ((r_valid >> k) != (AllOnes >> k));
        end
    end

    assign in_ready  = w_ready[0] & ~flush & ~RST;
    assign w_in_xfer = in_valid & in_ready;

    // Predecessor of each stage: upstream port for stage 0, previous stage otherwise.
    always_comb begin
        w_prev_valid    = '0;
        w_prev_valid[0] = w_in_xfer;
        w_prev_data[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_prev_valid[k] = r_valid[k-1];
            w_prev_data[k]  = r_data[k-1];
        end
    end

    // Stage registers: flush drops valid bits only; stalled stages hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_prev_valid[k];
                    r_data[k]  <= w_prev_data[k];
                end
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

`ifdef PIPE_OCC_EN
    localparam int unsigned OccW = $clog2(DEPTH+1);

    logic [OccW-1:0] r_occ;
    logic            w_out_xfer;

    assign w_out_xfer = out_valid & out_ready;

    // Count of valid stages, tracked from port transfers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + OccW'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - OccW'(1);
        end
    end

    assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: three instances (DEPTH 2, 3, 4),
// a vector table, directed multi-cycle sequences and a randomized run
// against a word-level reference model. Honours PIPE_OCC_EN if defined.
module tb_pipe_stage_chain;

    logic        CLK;
    logic        RST;
    logic        iv  [3];
    logic        ir  [3];
    logic [31:0] din [3];
    logic        ov  [3];
    logic        ordy[3];
    logic [31:0] od  [3];
    logic        fl  [3];
`ifdef PIPE_OCC_EN
    logic [3:0]  occ [3];
`endif

    int n_chk;
    int n_pass;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = g + 2;
`ifdef PIPE_OCC_EN
        logic [$clog2(D+1)-1:0] w_occ;
        assign occ[g] = 4'(w_occ);
`endif
        pipe_stage_chain #(.WL(32), .DEPTH(D)) u_dut (
            .CLK       (CLK),
            .RST       (RST),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (din[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (od[g]),
            .flush     (fl[g])
`ifdef PIPE_OCC_EN
            ,
            .occupancy (w_occ)
`endif
        );
    end

    // One vector: inputs for a cycle and the outputs expected before its edge.
    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic        chk_od;
        logic [31:0] e_od;
        int          e_occ;
    } vec_t;

    // Reference model: words in flight, oldest first, with their stage index.
    typedef struct {
        logic [31:0] data;
        int          pos;
    } slot_t;

    slot_t mq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic clear_inputs();
        for (int u = 0; u < 3; u++) begin
            iv[u] = 1'b0; din[u] = '0; ordy[u] = 1'b0; fl[u] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        clear_inputs();
        @(negedge CLK);
        RST = 1'b0;
        mq.delete();
    endtask

    // Drive one cycle's inputs on the falling edge; outputs settle 1 time unit later.
    task automatic drive(input int u, input logic v, input logic [31:0] d,
                         input logic r, input logic f);
        @(negedge CLK);
        iv[u] = v; din[u] = d; ordy[u] = r; fl[u] = f;
        #1;
    endtask

    task automatic run_table();
        vec_t tbl [19];
        tbl[0]  = '{1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0};
        tbl[1]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1};
        tbl[2]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1};
        tbl[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 1};
        tbl[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0};
        tbl[5]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0};
        tbl[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1};
        tbl[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1};
        tbl[8]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1};
        tbl[9]  = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 2};
        tbl[10] = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 3};
        tbl[11] = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 3};
        tbl[12] = '{1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 3};
        tbl[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 0};
        tbl[14] = '{1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0};
        tbl[15] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1};
        tbl[16] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1};
        tbl[17] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h66, 1};
        tbl[18] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0};
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive(1, tbl[i].iv, tbl[i].din, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_in_ready", i), 64'(ir[1]), 64'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 64'(ov[1]), 64'(tbl[i].e_ov));
            if (tbl[i].chk_od)
                chk($sformatf("tbl%0d_out_data", i), 64'(od[1]), 64'(tbl[i].e_od));
`ifdef PIPE_OCC_EN
            chk($sformatf("tbl%0d_occupancy", i), 64'(occ[1]), 64'(tbl[i].e_occ));
`endif
        end
    endtask

    // DEPTH=2: 16 back-to-back words stream through with no stall.
    task automatic run_stream();
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive(0, (i < 16), 32'(i), 1'b1, 1'b0);
            chk($sformatf("stream%0d_in_ready", i), 64'(ir[0]), 64'(1));
            chk($sformatf("stream%0d_out_valid", i), 64'(ov[0]), 64'(i >= 2 && i < 18));
            if (i >= 2 && i < 18)
                chk($sformatf("stream%0d_out_data", i), 64'(od[0]), 64'(i - 2));
        end
    endtask

    // DEPTH=4: stall with six words offered, then drain in order.
    task automatic run_backpressure();
        int acc;
        int nout;
        acc  = 0;
        nout = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(2, (acc < 6), 32'(100 + acc), 1'b0, 1'b0);
            if (iv[2] && ir[2]) acc++;
        end
        chk("bp_accepted", 64'(acc), 64'(4));
        chk("bp_in_ready_low", 64'(ir[2]), 64'(0));
        chk("bp_head_valid", 64'(ov[2]), 64'(1));
        chk("bp_head_data", 64'(od[2]), 64'(100));
`ifdef PIPE_OCC_EN
        chk("bp_occupancy", 64'(occ[2]), 64'(4));
`endif
        for (int c = 0; c < 30 && nout < 6; c++) begin
            drive(2, (acc < 6), 32'(100 + acc), 1'b1, 1'b0);
            if (ov[2]) begin
                chk($sformatf("bp_drain%0d", nout), 64'(od[2]), 64'(100 + nout));
                nout++;
            end
            if (iv[2] && ir[2]) acc++;
        end
        chk("bp_drained", 64'(nout), 64'(6));
        chk("bp_total_accepted", 64'(acc), 64'(6));
    endtask

    // DEPTH=3: asynchronous reset between edges while words are in flight.
    task automatic run_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 1'b1, 32'(200 + i), 1'b1, 1'b0);
        chk("ar_pre_valid", 64'(ov[1]), 64'(1));
        chk("ar_pre_data", 64'(od[1]), 64'(200));
        #2;
        RST = 1'b1;
        #1;
        chk("ar_out_valid", 64'(ov[1]), 64'(0));
        chk("ar_out_data", 64'(od[1]), 64'(0));
        chk("ar_in_ready", 64'(ir[1]), 64'(0));
        @(negedge CLK);
        RST = 1'b0;
        clear_inputs();
        for (int c = 0; c < 5; c++) begin
            drive(1, (c == 0), 32'h1, 1'b1, 1'b0);
            if (c == 0) chk("ar_new_accept", 64'(ir[1]), 64'(1));
            chk($sformatf("ar_lat%0d_valid", c), 64'(ov[1]), 64'(c == 3));
            if (c == 3) chk("ar_new_data", 64'(od[1]), 64'(1));
        end
    endtask

    task automatic run_random();
        for (int u = 0; u < 3; u++) begin
            int   dep;
            logic s_iv, s_or, s_fl, e_ir, e_ov;
            logic [31:0] s_d;
            bit   mv [8];
            dep = u + 2;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                s_iv = ($urandom_range(9) < 7);
                s_or = ($urandom_range(9) < 6);
                s_fl = ($urandom_range(19) == 0);
                s_d  = $urandom;
                drive(u, s_iv, s_d, s_or, s_fl);
                e_ir = !s_fl && (mq.size() < dep || s_or);
                e_ov = (mq.size() > 0) && (mq[0].pos == dep - 1);
                chk($sformatf("rnd_d%0d_c%0d_in_ready", dep, c), 64'(ir[u]), 64'(e_ir));
                chk($sformatf("rnd_d%0d_c%0d_out_valid", dep, c), 64'(ov[u]), 64'(e_ov));
                if (e_ov)
                    chk($sformatf("rnd_d%0d_c%0d_out_data", dep, c), 64'(od[u]),
                        64'(mq[0].data));
`ifdef PIPE_OCC_EN
                chk($sformatf("rnd_d%0d_c%0d_occ", dep, c), 64'(occ[u]), 64'(mq.size()));
`endif
                if (s_fl) begin
                    mq.delete();
                end else begin
                    // A word advances if an empty slot lies ahead of it or downstream drains.
                    for (int i = 0; i < mq.size(); i++)
                        mv[i] = (i < dep - 1 - mq[i].pos) || s_or;
                    for (int i = 0; i < mq.size(); i++)
                        if (mv[i]) mq[i].pos++;
                    if (mq.size() > 0 && mq[0].pos == dep) void'(mq.pop_front());
                    if (s_iv && e_ir) mq.push_back('{s_d, 0});
                end
            end
        end
    endtask

    task automatic run_all();
        for (int u = 0; u < 3; u++) iv[u] = 1'b1;
        #2;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst%0d_out_valid", u), 64'(ov[u]), 64'(0));
            chk($sformatf("rst%0d_out_data", u), 64'(od[u]), 64'(0));
            chk($sformatf("rst%0d_in_ready", u), 64'(ir[u]), 64'(0));
`ifdef PIPE_OCC_EN
            chk($sformatf("rst%0d_occ", u), 64'(occ[u]), 64'(0));
`endif
        end
        @(negedge CLK);
        RST = 1'b0;
        clear_inputs();
        #1;
        for (int u = 0; u < 3; u++)
            chk($sformatf("rel%0d_in_ready", u), 64'(ir[u]), 64'(1));
        run_table();
        run_stream();
        run_backpressure();
        run_async_reset();
        run_random();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        RST    = 1'b1;
        clear_inputs();
        run_all();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
